// File: rtl/adc_dly_calib.sv
// ADC input-delay calibration: per lane, sweeps 32 IDELAY taps, finds the
// longest passing window against a training pattern, and loads its centre.
// Ports: i_delay_clk/i_clr (async, active-high), i_start, i_delay_locked,
//   i_lane_data/i_pattern (7 lanes x 2 bits), o_dld (tap strobe per lane),
//   o_dwdata (7 lanes x 5-bit tap), o_busy, o_done, o_fail (per lane), o_err.
// Optional macro ADC_DLY_CAL_MANUAL_EN adds i_man_we/i_man_sel/i_man_tap
//   for direct tap writes while idle.
module adc_dly_calib #(
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLE_CNT = 64
) (
    input  logic        i_delay_clk,
    input  logic        i_clr,
    input  logic        i_start,
    input  logic        i_delay_locked,
    input  logic [13:0] i_lane_data,
    input  logic [13:0] i_pattern,
`ifdef ADC_DLY_CAL_MANUAL_EN
    input  logic        i_man_we,
    input  logic [2:0]  i_man_sel,
    input  logic [4:0]  i_man_tap,
`endif
    output logic [6:0]  o_dld,
    output logic [34:0] o_dwdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [6:0]  o_fail,
    output logic        o_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, LOAD, SETTLE, CHECK, NEXT, APPLY, DONE
    } state_t;

    localparam logic [9:0] SET_LAST = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] SMP_LAST = 10'(SAMPLE_CNT - 1);

    state_t      state_q, state_d;
    logic [2:0]  lane_q, lane_d;
    logic [4:0]  tap_q, tap_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic [4:0]  cur_start_q, cur_start_d;
    logic [5:0]  cur_len_q, cur_len_d;
    logic [4:0]  best_start_q, best_start_d;
    logic [5:0]  best_len_q, best_len_d;
    logic [6:0]  dld_q, dld_d;
    logic [34:0] dwdata_q, dwdata_d;
    logic [6:0]  fail_q, fail_d;
    logic        err_q, err_d;

    logic        lane_match;
    logic        abort;
    logic [5:0]  run_len;
    logic [4:0]  run_start;
    logic [4:0]  apply_tap;

    assign o_dld    = dld_q;
    assign o_dwdata = dwdata_q;
    assign o_fail   = fail_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q != IDLE) && (state_q != DONE);
    assign o_done   = (state_q == DONE);

    always_comb begin
        lane_match = i_lane_data[{lane_q, 1'b0} +: 2]
                     == i_pattern[{lane_q, 1'b0} +: 2];
        // Losing the IDELAYCTRL lock invalidates any tap measurement.
        abort = !i_delay_locked && (state_q inside {LOAD, SETTLE, CHECK, NEXT, APPLY});
        // Run that includes the tap just measured; a run still open at
        // tap 31 is thereby scored without a separate end-of-sweep step.
        run_len   = pass_q ? cur_len_q + 6'd1 : 6'd0;
        run_start = (pass_q && cur_len_q == 6'd0) ? tap_q : cur_start_q;
        apply_tap = (best_len_q == 6'd0) ? 5'd16
                  : best_start_q + best_len_q[5:1];
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        dld_d        = '0;
        dwdata_d     = dwdata_q;
        fail_d       = fail_q;
        err_d        = err_q;
        if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d      = WAIT_RDY;
                        lane_d       = '0;
                        tap_d        = '0;
                        fail_d       = '0;
                        err_d        = 1'b0;
                        cur_start_d  = '0;
                        cur_len_d    = '0;
                        best_start_d = '0;
                        best_len_d   = '0;
                    end
`ifdef ADC_DLY_CAL_MANUAL_EN
                    else if (i_man_we && i_man_sel != 3'd7) begin
                        dwdata_d[int'(i_man_sel) * 5 +: 5] = i_man_tap;
                        dld_d[i_man_sel] = 1'b1;
                    end
`endif
                end
                WAIT_RDY: begin
                    if (i_delay_locked) state_d = LOAD;
                end
                LOAD: begin
                    dwdata_d[int'(lane_q) * 5 +: 5] = tap_q;
                    dld_d[lane_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        cnt_d   = '0;
                        pass_d  = 1'b1;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                CHECK: begin
                    pass_d = pass_q & lane_match;
                    if (cnt_q == SMP_LAST) begin
                        cnt_d   = '0;
                        state_d = NEXT;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                NEXT: begin
                    cur_len_d   = run_len;
                    cur_start_d = run_start;
                    // Strictly longer only: the earliest of equal windows stays.
                    if (run_len > best_len_q) begin
                        best_len_d   = run_len;
                        best_start_d = run_start;
                    end
                    if (tap_q == 5'd31) begin
                        state_d = APPLY;
                    end else begin
                        tap_d   = tap_q + 5'd1;
                        state_d = LOAD;
                    end
                end
                APPLY: begin
                    dwdata_d[int'(lane_q) * 5 +: 5] = apply_tap;
                    dld_d[lane_q] = 1'b1;
                    if (best_len_q == 6'd0) fail_d[lane_q] = 1'b1;
                    if (lane_q == 3'd6) begin
                        state_d = DONE;
                        err_d   = |fail_d;
                    end else begin
                        lane_d       = lane_q + 3'd1;
                        tap_d        = '0;
                        cur_start_d  = '0;
                        cur_len_d    = '0;
                        best_start_d = '0;
                        best_len_d   = '0;
                        state_d      = LOAD;
                    end
                end
                DONE: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_delay_clk or posedge i_clr) begin
        if (i_clr) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            dld_q        <= '0;
            dwdata_q     <= '0;
            fail_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            dld_q        <= dld_d;
            dwdata_q     <= dwdata_d;
            fail_q       <= fail_d;
            err_q        <= err_d;
        end
    end

endmodule
